alu_seq_nb: RTL and testbench
=============================

// Module: alu_seq_nb
// PURPOSE
//  Parametrised, registered ALU with valid/ready handshake on input and output.
//  Single-cycle ADD/SUB/AND/OR/XOR, carry-chained ADC/SBB for multi-word math,
//  and an optional multi-cycle shift-and-add MUL. Full flag set (C/Z/N/V).
//  Sits between the operand fetch stage and writeback as the datapath execution unit.
// PARAMETERS
//  WIDTH   8  operand/result width in bits (>=2)
//  MUL_EN  1  1: opcode MUL implemented; 0: MUL decodes as undefined
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operands/opcode valid
//  in_ready   out  1      unit can accept an operation this cycle
//  a, b       in   WIDTH  operands
//  opcode     in   4      operation select (see BEHAVIOUR)
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  carry_out  out  1      C flag of this result
//  zero       out  1      result == 0
//  negative   out  1      result[WIDTH-1]
//  overflow   out  1      signed overflow (ADD/SUB/ADC/SBB only, else 0)
//  busy       out  1      MUL in progress
// BEHAVIOUR
//  Opcodes: 0 ADD a+b; 1 SUB a+~b+1; 2 AND; 3 OR; 4 XOR; 5 ADC a+b+cf;
//   6 SBB a+~b+cf; 7 MUL low WIDTH bits of a*b (unsigned); 8-15 undefined.
//  cf = internal carry register; updated only when an ADD/SUB/ADC/SBB/MUL result
//   loads the output register; logic/undefined ops leave cf unchanged.
//  SUB/SBB carry = NOT borrow (1 when a >= b for SUB). MUL carry = |high half.
//  V = (a_msb==b'_msb) && (res_msb!=a_msb), b' = b or ~b for subtract forms.
//  Undefined: result 0, C=0, V=0, Z=1, N=0; accepted and completed normally.
//  FSM: IDLE, MUL. in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Accept = in_valid && in_ready. Non-MUL accepted at edge k -> out_valid at k+1.
//  MUL accepted at edge k -> IDLE->MUL, busy=1, WIDTH iterations, result loads
//   and out_valid rises at edge k+WIDTH; FSM returns to IDLE same edge.
//  Output regs hold stable while out_valid && !out_ready; out_valid clears on
//   out_ready if no new result loads that edge. Back-to-back issue: new op may
//   be accepted on the same edge the previous result is consumed (1 op/cycle).
//  MUL completion while out_valid && !out_ready cannot occur: MUL accepted only
//   when output register free; output register is reserved during MUL.
//  ADC/SBB read cf as of the accept edge (includes the immediately preceding op).
//  Arithmetic at WIDTH+1 bits internally; result = low WIDTH bits, C = bit WIDTH.
//  Reset: state IDLE, out_valid 0, result 0, all flags 0, cf 0, busy 0;
//   in_ready 1 the cycle after reset deasserts. Reset mid-MUL aborts, no output.
//  in_valid held with changing operands while in_ready=0: ignored, no capture.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_ADD..OP_MUL), FSM state encoding.
//  Sub-module addsub_nb #(WIDTH): ripple add/sub with cin and invert-b control,
//   outputs sum, carry, overflow; one instance shared by all add/sub opcodes.
//  MUL datapath (accumulator, shifted multiplicand, counter) generated only if MUL_EN.
// TESTING
//  WIDTH=8: ADD FF+01 -> result 00, C1 Z1 N0 V0, out_valid one cycle after accept.
//  SUB 05-07 -> FE, C0 N1 V0; ADD 7F+01 -> 80, V1 N1 C0.
//  16-bit chain: ADD FF+01 -> 00 C1, then ADC 00+00 -> 01 C0 (cf consumed).
//  MUL 0D*0B -> 8F C0 after exactly 8 busy cycles; MUL FF*02 -> FE C1.
//  Backpressure: out_ready=0 for 5 cycles -> result/flags stable, in_ready=0;
//   release -> next queued op accepted same edge.
//  rst at 3rd MUL cycle -> busy 0, out_valid 0, cf 0; next ADD 01+01 -> 02.
//  MUL_EN=0: opcode 7 -> result 00, Z1, completes in one cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and
// the controller state encoding used by alu_seq_nb.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBB = 4'd6;
    localparam logic [3:0] OP_MUL = 4'd7;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_nb.sv
// Adder/subtractor shared by all add/sub opcodes, computed at WIDTH+1 bits.
// Ports: a, b operands; cin carry in; sub inverts b; sum, carry, overflow out.
module addsub_nb #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   full;

    assign bx   = sub ? ~b : b;
    assign full = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
    assign sum  = full[WIDTH-1:0];
    assign carry = full[WIDTH];

    // Signed overflow: operands agree in sign, result disagrees.
    assign overflow = (a[WIDTH-1] == bx[WIDTH-1])
                   && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq_nb.sv
// Registered ALU with valid/ready handshakes, carry chaining and optional MUL.
// Ports: clk, rst; in_valid/in_ready, a, b, opcode; out_valid/out_ready,
//        result, carry_out, zero, negative, overflow; busy during MUL.
module alu_seq_nb
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output logic             negative,
    output logic             overflow,
    output logic             busy
);

    state_t state;
    state_t state_nxt;

    logic             cf;
    logic             accept;
    logic             mul_start;
    logic             mul_done;
    logic [WIDTH-1:0] mul_lo;
    logic             mul_hi_nz;

    logic             as_sub;
    logic             as_cin;
    logic [WIDTH-1:0] as_sum;
    logic             as_c;
    logic             as_v;

    logic [WIDTH-1:0] op_res;
    logic             op_c;
    logic             op_v;
    logic             op_arith;

    assign accept    = in_valid && in_ready;
    assign mul_start = accept && (opcode == OP_MUL) && MUL_EN;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (mul_start) state_nxt = ST_MUL;
            ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == ST_IDLE) && (!out_valid || out_ready);
        busy     = (state == ST_MUL);
    end

    // Subtract forms invert b; ADC/SBB take the stored carry as cin.
    assign as_sub = (opcode == OP_SUB) || (opcode == OP_SBB);
    assign as_cin = (opcode == OP_SUB)
                 || (((opcode == OP_ADC) || (opcode == OP_SBB)) && cf);

    addsub_nb #(.WIDTH(WIDTH)) u_addsub (
        .a        (a),
        .b        (b),
        .cin      (as_cin),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_c),
        .overflow (as_v)
    );

    always_comb begin
        op_res   = '0;
        op_c     = 1'b0;
        op_v     = 1'b0;
        op_arith = 1'b0;
        unique case (opcode)
            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                op_res   = as_sum;
                op_c     = as_c;
                op_v     = as_v;
                op_arith = 1'b1;
            end
            OP_AND:  op_res = a & b;
            OP_OR:   op_res = a | b;
            OP_XOR:  op_res = a ^ b;
            default: op_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            cf        <= 1'b0;
        end else if (accept && !mul_start) begin
            out_valid <= 1'b1;
            result    <= op_res;
            carry_out <= op_c;
            zero      <= (op_res == '0);
            negative  <= op_res[WIDTH-1];
            overflow  <= op_v;
            if (op_arith) cf <= op_c;
        end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_lo;
            carry_out <= mul_hi_nz;
            zero      <= (mul_lo == '0);
            negative  <= mul_lo[WIDTH-1];
            overflow  <= 1'b0;
            cf        <= mul_hi_nz;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    generate
        if (MUL_EN) begin : g_mul
            localparam int CW = $clog2(WIDTH);
            localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

            logic [2*WIDTH-1:0] acc;
            logic [2*WIDTH-1:0] mcand;
            logic [2*WIDTH-1:0] acc_nxt;
            logic [WIDTH-1:0]   mplier;
            logic [CW-1:0]      cnt;

            // One multiplier bit per cycle; the final sum bypasses acc.
            assign acc_nxt   = acc + (mplier[0] ? mcand : '0);
            assign mul_done  = (state == ST_MUL) && (cnt == LAST);
            assign mul_lo    = acc_nxt[WIDTH-1:0];
            assign mul_hi_nz = |acc_nxt[2*WIDTH-1:WIDTH];

            always_ff @(posedge clk) begin
                if (rst) begin
                    acc    <= '0;
                    mcand  <= '0;
                    mplier <= '0;
                    cnt    <= '0;
                end else if (mul_start) begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, a};
                    mplier <= b;
                    cnt    <= '0;
                end else if (state == ST_MUL) begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                end
            end
        end else begin : g_nomul
            assign mul_done  = 1'b0;
            assign mul_lo    = '0;
            assign mul_hi_nz = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_alu_seq_nb.sv
// Scoreboard bench for alu_seq_nb (WIDTH=8) plus a MUL_EN=0 instance.
module tb_alu_seq_nb;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3;
    localparam logic [3:0] XOR_ = 4'd4, ADC = 4'd5, SBB = 4'd6, MUL = 4'd7;

    typedef struct packed {
        logic [7:0] r;
        logic c, z, n, v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, out_valid, out_ready;
    logic [7:0] a, b, result;
    logic [3:0] opcode;
    logic carry_out, zero, negative, overflow, busy;

    logic in_valid_u, in_ready_u, out_valid_u, out_ready_u;
    logic [7:0] result_u;
    logic carry_u, zero_u, neg_u, ovf_u, busy_u;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_seq_nb #(.WIDTH(8), .MUL_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .opcode(opcode), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .carry_out(carry_out),
        .zero(zero), .negative(negative), .overflow(overflow), .busy(busy)
    );

    alu_seq_nb #(.WIDTH(8), .MUL_EN(1'b0)) dut_nomul (
        .clk(clk), .rst(rst), .in_valid(in_valid_u), .in_ready(in_ready_u),
        .a(8'h0D), .b(8'h0B), .opcode(MUL), .out_valid(out_valid_u),
        .out_ready(out_ready_u), .result(result_u), .carry_out(carry_u),
        .zero(zero_u), .negative(neg_u), .overflow(ovf_u), .busy(busy_u)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output got=%0h want=none", result);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result_flags",
                    {19'd0, result, carry_out, zero, negative, overflow},
                    {19'd0, e});
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [7:0] x, y,
                         input logic [7:0] er, input logic ec, ez, en, ev,
                         input bit push);
        int n = 0;
        opcode = op; a = x; b = y; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout got=0 want=1");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sb.push_back('{er, ec, ez, en, ev});
        #1;
        in_valid = 1'b0;
        if (op != MUL) chk("latency_valid", 32'(out_valid), 32'd1);
        else           chk("mul_busy", 32'(busy), 32'd1);
    endtask

    task automatic mul_wait();
        int j = 0;
        while (!out_valid && j < 20) begin
            @(posedge clk); #1; j++;
        end
        chk("mul_cycles", 32'(j), 32'd8);
        chk("mul_busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        int hits;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; opcode = '0;
        in_valid_u = 1'b0; out_ready_u = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("reset_state",
            {20'd0, out_valid, result, carry_out, zero, negative, overflow, busy},
            {20'd0, 1'b0, 8'h00, 5'b00000});
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        in_valid_u = 1'b1;
        @(posedge clk); #1;
        in_valid_u = 1'b0;
        chk("nomul_op7",
            {20'd0, out_valid_u, result_u, carry_u, zero_u, neg_u, ovf_u, busy_u},
            {20'd0, 1'b1, 8'h00, 5'b01000});

        issue(ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1);
        issue(SUB, 8'h05, 8'h07, 8'hFE, 0, 0, 1, 0, 1);
        issue(ADD, 8'h7F, 8'h01, 8'h80, 0, 0, 1, 1, 1);
        issue(ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1);
        issue(ADC, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 1);
        issue(ADD, 8'h80, 8'h80, 8'h00, 1, 1, 0, 1, 1);
        issue(OR_, 8'h12, 8'h04, 8'h16, 0, 0, 0, 0, 1);
        issue(XOR_, 8'hAA, 8'h55, 8'hFF, 0, 0, 1, 0, 1);
        issue(AND_, 8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0, 1);
        issue(ADC, 8'h01, 8'h01, 8'h03, 0, 0, 0, 0, 1);
        issue(SBB, 8'h10, 8'h01, 8'h0E, 1, 0, 0, 0, 1);
        issue(SBB, 8'h10, 8'h01, 8'h0F, 1, 0, 0, 0, 1);
        issue(SUB, 8'h07, 8'h07, 8'h00, 1, 1, 0, 0, 1);
        issue(4'd9, 8'hFF, 8'hFF, 8'h00, 0, 1, 0, 0, 1);
        issue(ADC, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 1);

        issue(MUL, 8'h0D, 8'h0B, 8'h8F, 0, 0, 1, 0, 1);
        mul_wait();
        issue(MUL, 8'hFF, 8'h02, 8'hFE, 1, 0, 1, 0, 1);
        mul_wait();
        issue(ADC, 8'h00, 8'h00, 8'h01, 0, 0, 0, 0, 1);

        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(ADD, 8'h01, 8'h02, 8'h03, 0, 0, 0, 0, 1);
        opcode = ADD; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            a = 8'(i * 17 + 5); b = 8'(i + 9);
            @(posedge clk); #1;
            chk("bp_hold", {22'd0, in_ready, out_valid, result},
                {22'd0, 1'b0, 1'b1, 8'h03});
        end
        a = 8'h03; b = 8'h04; out_ready = 1'b1;
        sb.push_back('{8'h07, 1'b0, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp_release", {23'd0, out_valid, result}, {23'd0, 1'b1, 8'h07});

        issue(ADD, 8'hFF, 8'h01, 8'h00, 1, 1, 0, 0, 1);
        issue(MUL, 8'h03, 8'h03, 8'h09, 0, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_mid_mul", {29'd0, busy, out_valid, in_ready},
            {29'd0, 3'b001});
        hits = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (out_valid) hits++;
        end
        chk("rst_no_output", 32'(hits), 32'd0);
        issue(ADC, 8'h00, 8'h00, 8'h00, 0, 1, 0, 0, 1);
        issue(ADD, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0, 1);

        for (int k = 0; k < 50 && sb.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
